// File: rtl/generic_2clk_fifo_rd_stream_pkg.sv
// rtl/generic_2clk_fifo_rd_stream_pkg.sv - shared constants and types for the FIFO read-side stream adapter
package generic_2clk_fifo_rd_stream_pkg;

   localparam int DAT_WIDTH_DEF = 36;
   localparam int SKID_DEPTH    = 2;
   localparam int CNT_W         = 2;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      BUF_IDLE = 2'b00,
      BUF_POP  = 2'b01,
      BUF_PUSH = 2'b10,
      BUF_BOTH = 2'b11
   } buf_op_e;

   // Free slots left once the word already in flight lands; a fire this cycle frees one more.
   function automatic logic [2:0] pop_credit(input cnt_t cnt, input logic inflight, input logic fire);
      return 3'(SKID_DEPTH) - {1'b0, cnt} - {2'b00, inflight} + {2'b00, fire};
   endfunction

endpackage

// File: rtl/generic_skid_buf2.sv
// rtl/generic_skid_buf2.sv - two-slot register buffer with push, pop, clear and occupancy count
module generic_skid_buf2
   import generic_2clk_fifo_rd_stream_pkg::*;
#(
   parameter int DAT_WIDTH = DAT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 push,
   input  logic [DAT_WIDTH-1:0] push_data,
   input  logic                 pop,
   output logic [DAT_WIDTH-1:0] head,
   output cnt_t                 cnt
);

   logic [DAT_WIDTH-1:0] head_q;
   logic [DAT_WIDTH-1:0] tail_q;
   cnt_t                 cnt_q;
   buf_op_e              op;

   assign op   = buf_op_e'({push, pop});
   assign head = head_q;
   assign cnt  = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else begin
         case (op)
            BUF_PUSH: begin
               if (cnt_q == '0) head_q <= push_data;
               else             tail_q <= push_data;
               cnt_q <= cnt_q + 1'b1;
            end
            BUF_POP: begin
               if (cnt_q == 2'd2) head_q <= tail_q;
               cnt_q <= cnt_q - 1'b1;
            end
            // Count unchanged: the incoming word goes wherever the post-pop occupancy points.
            BUF_BOTH: begin
               if (cnt_q == 2'd2) begin
                  head_q <= tail_q;
                  tail_q <= push_data;
               end else begin
                  head_q <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/generic_2clk_fifo_rd_stream.sv
// rtl/generic_2clk_fifo_rd_stream.sv - turns the FIFO pop/read-data interface into a registered valid/ready stream
module generic_2clk_fifo_rd_stream
   import generic_2clk_fifo_rd_stream_pkg::*;
#(
   parameter int DAT_WIDTH = DAT_WIDTH_DEF
) (
   input  logic                 rd_clk,
   input  logic                 rd_reset_n,
   input  logic                 rd_empty,
   input  logic [DAT_WIDTH-1:0] rd_data,
   output logic                 rd_op,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DAT_WIDTH-1:0] out_data,
   output logic [1:0]           out_level
);

   logic       run;
   logic       inflight;
   logic       discard;
   logic       fire;
   logic       push;
   logic [2:0] credit;
   cnt_t       cnt;

   assign out_valid = (cnt != '0);
   assign out_level = cnt;
   assign fire      = out_valid & out_ready;
   assign credit    = pop_credit(cnt, inflight, fire);

   // run holds pops off until the first edge after reset release.
   assign rd_op = run & ~rd_empty & ~flush & (credit != 3'd0);
   assign push  = inflight & ~discard & ~flush;

   always_ff @(posedge rd_clk or negedge rd_reset_n) begin
      if (!rd_reset_n) begin
         run      <= 1'b0;
         inflight <= 1'b0;
         discard  <= 1'b0;
      end else begin
         run      <= 1'b1;
         inflight <= rd_op;
         discard  <= flush & rd_op;
      end
   end

   generic_skid_buf2 #(
      .DAT_WIDTH (DAT_WIDTH)
   ) u_buf (
      .clk       (rd_clk),
      .rst_n     (rd_reset_n),
      .clear     (flush),
      .push      (push),
      .push_data (rd_data),
      .pop       (fire),
      .head      (out_data),
      .cnt       (cnt)
   );

   a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_reset_n)
      ({1'b0, cnt} + {2'b00, inflight}) <= 3'd2);

endmodule
